// File: rtl/hc299_univ_shift_reg_pkg.sv
// Shared definitions for the 74HC299 universal shift/storage register model:
// byte width, mode encoding and the I/O drive-enable decode.
package hc299_univ_shift_reg_pkg;

    localparam int HC_BYTE_W = 8;

    typedef enum logic [1:0] {
        HC_MODE_HOLD = 2'b00,
        HC_MODE_SHR  = 2'b01,
        HC_MODE_SHL  = 2'b10,
        HC_MODE_LOAD = 2'b11
    } hc_mode_e;

    // Pins are driven only with both enables low and never in LOAD mode.
    function automatic logic hc_drive_en(
        input hc_mode_e mode,
        input logic     oe1_n,
        input logic     oe2_n
    );
        return (oe1_n == 1'b0) && (oe2_n == 1'b0) && (mode != HC_MODE_LOAD);
    endfunction

endpackage

// File: rtl/hc299_cell.sv
// One bit of the HC299 register: 4:1 next-state mux plus a DFF that is
// forced to its clear value while rst_n is low.
module hc299_cell
    import hc299_univ_shift_reg_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clr_val,
    input  hc_mode_e mode,
    input  logic     left_in,
    input  logic     right_in,
    input  logic     par_in,
    output logic     q
);

    logic w_d;
    logic r_q;

    // Next-state selection: left_in feeds shift-right, right_in feeds shift-left.
    always_comb begin
        w_d = r_q;
        case (mode)
            HC_MODE_HOLD: w_d = r_q;
            HC_MODE_SHR:  w_d = left_in;
            HC_MODE_SHL:  w_d = right_in;
            HC_MODE_LOAD: w_d = par_in;
            default:      w_d = r_q;
        endcase
    end

    // Storage flop with asynchronous clear to the configured value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= clr_val;
        end else begin
            r_q <= w_d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hc299_univ_shift_reg.sv
// 74HC299 8-bit universal shift/storage register with 3-state bidirectional I/O.
// Pin-numbered ports; this level only maps pins to bit indices and decodes OE.
module hc299_univ_shift_reg
    import hc299_univ_shift_reg_pkg::*;
#(
    parameter logic [HC_BYTE_W-1:0] CLR_VAL = 8'h00
)(
    input  logic p12,
    input  logic p9,
    input  logic p1,
    input  logic p19,
    input  logic p2,
    input  logic p3,
    input  logic p11,
    input  logic p18,
    inout  wire  p7,
    inout  wire  p13,
    inout  wire  p6,
    inout  wire  p14,
    inout  wire  p5,
    inout  wire  p15,
    inout  wire  p4,
    inout  wire  p16,
    output logic p8,
    output logic p17
);

    hc_mode_e               w_mode;
    logic                   w_oe;
    logic [HC_BYTE_W-1:0]   w_pin_in;
    logic [HC_BYTE_W-1:0]   w_q;
    logic [HC_BYTE_W+1:0]   w_chain;

    assign w_mode   = hc_mode_e'({p19, p1});
    assign w_oe     = hc_drive_en(w_mode, p2, p3);
    assign w_pin_in = {p16, p4, p15, p5, p14, p6, p13, p7};

    // Chain index k+1 holds Q[k]; the two ends are the serial inputs.
    assign w_chain  = {p18, w_q, p11};

    for (genvar g = 0; g < HC_BYTE_W; g++) begin : g_cell
        hc299_cell u_cell (
            .clk      (p12),
            .rst_n    (p9),
            .clr_val  (CLR_VAL[g]),
            .mode     (w_mode),
            .left_in  (w_chain[g]),
            .right_in (w_chain[g+2]),
            .par_in   (w_pin_in[g]),
            .q        (w_q[g])
        );
    end

    assign p7  = w_oe ? w_q[0] : 1'bz;
    assign p13 = w_oe ? w_q[1] : 1'bz;
    assign p6  = w_oe ? w_q[2] : 1'bz;
    assign p14 = w_oe ? w_q[3] : 1'bz;
    assign p5  = w_oe ? w_q[4] : 1'bz;
    assign p15 = w_oe ? w_q[5] : 1'bz;
    assign p4  = w_oe ? w_q[6] : 1'bz;
    assign p16 = w_oe ? w_q[7] : 1'bz;

    assign p8  = w_q[0];
    assign p17 = w_q[7];

endmodule

// File: tb/tb_hc299_univ_shift_reg.sv
// Self-checking bench for hc299_univ_shift_reg: directed datasheet scenarios
// plus randomized traffic against a byte-level reference model.
module tb_hc299_univ_shift_reg;

    logic clk = 1'b0;
    logic mr_n, s0, s1, oe1_n, oe2_n, dsr, dsl;
    logic q0s, q7s;
    logic       tb_drv;
    logic [7:0] tb_val;
    wire io0, io1, io2, io3, io4, io5, io6, io7;
    logic [7:0] bus;
    logic [7:0] q_model;
    int checks = 0;
    int errors = 0;

    assign io0 = tb_drv ? tb_val[0] : 1'bz;
    assign io1 = tb_drv ? tb_val[1] : 1'bz;
    assign io2 = tb_drv ? tb_val[2] : 1'bz;
    assign io3 = tb_drv ? tb_val[3] : 1'bz;
    assign io4 = tb_drv ? tb_val[4] : 1'bz;
    assign io5 = tb_drv ? tb_val[5] : 1'bz;
    assign io6 = tb_drv ? tb_val[6] : 1'bz;
    assign io7 = tb_drv ? tb_val[7] : 1'bz;
    assign bus = {io7, io6, io5, io4, io3, io2, io1, io0};

    always #5 clk = ~clk;

    hc299_univ_shift_reg #(.CLR_VAL(8'h00)) dut (
        .p12(clk), .p9(mr_n), .p1(s0), .p19(s1), .p2(oe1_n), .p3(oe2_n),
        .p11(dsr), .p18(dsl),
        .p7(io0), .p13(io1), .p6(io2), .p14(io3), .p5(io4), .p15(io5), .p4(io6), .p16(io7),
        .p8(q0s), .p17(q7s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        s1 = m[1];
        s0 = m[0];
    endtask

    // Model update: shifts expressed as byte arithmetic.
    task automatic model_edge(input logic [1:0] m, input logic [7:0] pins);
        case (m)
            2'd1:    q_model = 8'((q_model * 2) + {7'd0, dsr});
            2'd2:    q_model = 8'((q_model / 2) + (dsl ? 8'd128 : 8'd0));
            2'd3:    q_model = pins;
            default: q_model = q_model;
        endcase
    endtask

    task automatic load_byte(input logic [7:0] v);
        set_mode(2'b11);
        tb_drv = 1'b1;
        tb_val = v;
        step();
        model_edge(2'b11, v);
        tb_drv = 1'b0;
        set_mode(2'b00);
        #1;
    endtask

    task automatic test_reset();
        mr_n = 1'b0;
        #1;
        checks++;
        if ({q7s, q0s} !== 2'b00) begin
            errors++;
            $display("FAIL reset_init: got q7q0=%b expected 00", {q7s, q0s});
        end
        mr_n = 1'b1;
        q_model = 8'h00;
        step();
        load_byte(8'hA5);
        set_mode(2'b01);
        dsr = 1'b1;
        step();
        model_edge(2'b01, 8'h00);
        checks++;
        if (bus !== q_model) begin
            errors++;
            $display("FAIL reset_preshift: got %h expected %h", bus, q_model);
        end
        #2;
        mr_n = 1'b0;
        #1;
        q_model = 8'h00;
        checks++;
        if ({q7s, q0s} !== 2'b00 || bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got q7q0=%b bus=%h expected 00 bus=00", {q7s, q0s}, bus);
        end
        step();
        checks++;
        if (bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 00", bus);
        end
        mr_n = 1'b1;
        set_mode(2'b00);
        #1;
    endtask

    task automatic test_load_readback();
        load_byte(8'h3C);
        checks++;
        if (bus !== 8'h3C || q_model !== 8'h3C) begin
            errors++;
            $display("FAIL load_readback: got %h expected 3c", bus);
        end
    endtask

    task automatic test_shift_right();
        load_byte(8'h01);
        dsr = 1'b0;
        set_mode(2'b01);
        for (int e = 1; e <= 8; e++) begin
            step();
            model_edge(2'b01, 8'h00);
            checks++;
            if (bus !== q_model) begin
                errors++;
                $display("FAIL shr_bus edge%0d: got %h expected %h", e, bus, q_model);
            end
            if (e == 1) begin
                checks++;
                if (q0s !== 1'b0) begin
                    errors++;
                    $display("FAIL shr_q0_edge1: got %b expected 0", q0s);
                end
            end else if (e == 7) begin
                checks++;
                if (q7s !== 1'b1) begin
                    errors++;
                    $display("FAIL shr_q7_edge7: got %b expected 1", q7s);
                end
            end else if (e == 8) begin
                checks++;
                if (bus !== 8'h00) begin
                    errors++;
                    $display("FAIL shr_final: got %h expected 00", bus);
                end
            end
        end
        set_mode(2'b00);
    endtask

    task automatic test_shift_left();
        load_byte(8'h80);
        dsl = 1'b1;
        set_mode(2'b10);
        repeat (4) begin
            step();
            model_edge(2'b10, 8'h00);
        end
        checks++;
        if (bus !== 8'hF8 || q0s !== 1'b0 || q7s !== 1'b1) begin
            errors++;
            $display("FAIL shl_final: got bus=%h q0=%b q7=%b expected f8 0 1", bus, q0s, q7s);
        end
        set_mode(2'b00);
    endtask

    task automatic test_tristate();
        load_byte(8'hA5);
        // Bench drives the complement; any DUT drive would corrupt the read.
        tb_val = 8'h5A;
        tb_drv = 1'b1;
        oe1_n = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h5A || q0s !== 1'b1 || q7s !== 1'b1) begin
            errors++;
            $display("FAIL tri_oe1: got bus=%h q0=%b q7=%b expected 5a 1 1", bus, q0s, q7s);
        end
        oe1_n = 1'b0;
        oe2_n = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h5A) begin
            errors++;
            $display("FAIL tri_oe2: got %h expected 5a", bus);
        end
        oe2_n = 1'b0;
        set_mode(2'b11);
        #1;
        checks++;
        if (bus !== 8'h5A) begin
            errors++;
            $display("FAIL tri_load_mode: got %h expected 5a", bus);
        end
        set_mode(2'b00);
        oe1_n = 1'b1;
        #1;
        tb_drv = 1'b0;
        oe1_n = 1'b0;
        #1;
        checks++;
        if (bus !== 8'hA5) begin
            errors++;
            $display("FAIL tri_redrive: got %h expected a5", bus);
        end
    endtask

    task automatic test_reset_vs_edge();
        set_mode(2'b11);
        tb_val = 8'hFF;
        tb_drv = 1'b1;
        mr_n = 1'b0;
        q_model = 8'h00;
        step();
        checks++;
        if ({q7s, q0s} !== 2'b00) begin
            errors++;
            $display("FAIL rst_dominates: got q7q0=%b expected 00", {q7s, q0s});
        end
        mr_n = 1'b1;
        step();
        model_edge(2'b11, 8'hFF);
        tb_drv = 1'b0;
        set_mode(2'b00);
        #1;
        checks++;
        if (bus !== 8'hFF || q_model !== 8'hFF) begin
            errors++;
            $display("FAIL rst_release_load: got %h expected ff", bus);
        end
    endtask

    task automatic test_random();
        logic [1:0] m;
        logic       en;
        for (int n = 0; n < 300; n++) begin
            m     = 2'($urandom_range(0, 3));
            oe1_n = ($urandom_range(0, 3) == 0);
            oe2_n = ($urandom_range(0, 3) == 0);
            dsr   = 1'($urandom);
            dsl   = 1'($urandom);
            set_mode(m);
            en = !oe1_n && !oe2_n && (m != 2'b11);
            tb_drv = !en;
            tb_val = 8'($urandom);
            #1;
            checks++;
            if (bus !== (en ? q_model : tb_val)) begin
                errors++;
                $display("FAIL rnd_pre[%0d]: got %h expected %h", n, bus, en ? q_model : tb_val);
            end
            if ($urandom_range(0, 15) == 0) begin
                mr_n = 1'b0;
                q_model = 8'h00;
                step();
                mr_n = 1'b1;
            end else begin
                step();
                model_edge(m, tb_val);
            end
            checks++;
            if (q0s !== q_model[0] || q7s !== q_model[7] || bus !== (en ? q_model : tb_val)) begin
                errors++;
                $display("FAIL rnd_post[%0d]: got q0=%b q7=%b bus=%h expected q=%h", n, q0s, q7s, bus, q_model);
            end
        end
        tb_drv = 1'b0;
        oe1_n = 1'b0;
        oe2_n = 1'b0;
        set_mode(2'b00);
    endtask

    initial begin
        mr_n = 1'b1; s0 = 1'b0; s1 = 1'b0; oe1_n = 1'b0; oe2_n = 1'b0;
        dsr = 1'b0; dsl = 1'b0; tb_drv = 1'b0; tb_val = 8'h00; q_model = 8'h00;
        #2;
        test_reset();
        test_load_readback();
        test_shift_right();
        test_shift_left();
        test_tristate();
        test_reset_vs_edge();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
